ramdisk_io_ctrl: RTL and testbench
==================================

Name: ramdisk_io_ctrl

Overview:
- IO-mapped RAM-disk access engine for the 512K/1M expansion SRAM.
- The CPU loads a 19-bit byte pointer through IO registers, then streams bytes through a DATA register with auto-increment.
- The block sequences SRAM read/write cycles and shares the SRAM with normal expansion-RAM memory cycles; memory cycles always win.
- It sits beside the bank-mapping logic, which muxes SRAM address/strobes to this block whenever sram_own=1.

Parameters:
WR_CYCLES, 2, clocks sram_we_b held low per write (1..7)
RD_CYCLES, 2, clocks from sram_oe_b low to rdata sample (1..7)
ADR_W, 19, SRAM byte address width (19 = 512K, 20 = 1M)

Ports:
clk  in  1  system clock (CPC 4MHz)
reset_b  in  1  asynchronous active-low reset
io_wr_stb  in  1  one-clock pulse: CPU IO write to this block (bus decode done upstream)
io_rd_stb  in  1  one-clock pulse: CPU IO read from this block
io_reg  in  2  register select: 0 ADR_LO, 1 ADR_MID, 2 ADR_HI/STATUS, 3 DATA
io_wdata  in  8  IO write data
io_rdata  out  8  IO read data, valid while wait_b=1 in the cycle after io_rd_stb
wait_b  out  1  low = stall CPU (drives READY via open-drain upstream)
cpu_req  in  1  expansion-RAM memory cycle active (mreq decode & card selected)
sram_own  out  1  1 = this block owns SRAM address/strobes
sram_adr  out  ADR_W  SRAM address
sram_wdata  out  8  SRAM write data (bus driven only when sram_own & !sram_we_b)
sram_rdata  in  8  SRAM read data
sram_cs_b  out  1  SRAM chip select
sram_oe_b  out  1  SRAM output enable
sram_we_b  out  1  SRAM write enable

Behaviour:
- Reset (async): ptr=0, rbuf=0, rbuf_valid=0, wbuf_pend=0, FSM=IDLE, sram_cs_b=sram_oe_b=sram_we_b=1, sram_own=0, wait_b=1, io_rdata=0.
- Reset mid-access: all strobes go inactive immediately; the in-flight write is lost, with no partial-state guarantee.
- Register writes:
  - ADR_LO, ADR_MID and ADR_HI load ptr[7:0], ptr[15:8] and ptr[ADR_W-1:16]; excess high bits are ignored.
  - Writing ADR_LO clears rbuf_valid and queues a prefetch read at ptr.
- Register reads:
  - ADR regs return ptr bytes.
  - ADR_HI read: bit7 = busy (FSM!=IDLE or pending op), bit6 = rbuf_valid; unused bits read 0.
- DATA write:
  - If wbuf_pend=1, wait_b goes low until the previous write completes, then the new byte is accepted.
  - Otherwise the byte is latched to wbuf and wbuf_pend=1.
  - On completion: ptr+1 (wraps 2^ADR_W-1 -> 0), rbuf_valid=0, prefetch queued.
- DATA read:
  - If rbuf_valid=0, wait_b goes low until the prefetch completes.
  - Otherwise io_rdata=rbuf the next cycle, ptr+1 with wrap, rbuf_valid=0, prefetch queued.
- Priority: a pending write is served before a prefetch.
- FSM states: IDLE, ARB, WR_SETUP (1 clk, cs low, addr/data stable), WR_PULSE (WR_CYCLES clks, we low), WR_HOLD (1 clk, we high, cs low), RD_SETUP (1 clk, cs+oe low), RD_WAIT (RD_CYCLES-1 clks), RD_SAMPLE (capture rbuf, rbuf_valid=1).
- Transitions:
  - IDLE -> ARB when any op is pending.
  - ARB -> *_SETUP when cpu_req=0; otherwise stay in ARB with sram_own=0.
  - End of WR_HOLD or RD_SAMPLE -> IDLE.
- sram_own=1 in all states except IDLE and ARB.
- Preemption: cpu_req=1 in any access state aborts the access.
  - Strobes go inactive and sram_own=0 in the same clock (combinational release).
  - FSM -> ARB; the op stays pending and restarts from SETUP.
  - ptr does not change on abort.
- Latency with no contention: write = 2+WR_CYCLES clks from accept to IDLE; prefetch = 2+RD_CYCLES clks.
- Simultaneous ADR write and op completion: the ADR write wins. A completing read is discarded (rbuf_valid stays 0), and the ptr increment is suppressed.
- Simultaneous io_wr_stb and io_rd_stb is illegal; the write takes precedence.

Test Plan:
- Reset, write ADR 0x12,0x34,0x05 -> ptr=0x53412; prefetch issues sram_adr=0x53412 after 1 clk, rbuf_valid after 4 clks; status read = 0x45.
- Set ptr=0x7FFFF, DATA write 0xA5 -> SRAM write at 0x7FFFF with we_b low 2 clks; ptr wraps to 0x00000; prefetch at 0.
- Three back-to-back DATA reads, SRAM preloaded 0x11,0x22,0x33 from 0x100 -> returns 11,22,33; wait_b low on reads 2 and 3 until each prefetch lands; final ptr=0x103.
- cpu_req asserted during WR_PULSE -> strobes released same clk, sram_own=0; after cpu_req falls, write restarts and completes once; ptr increments once.
- Two DATA writes one clock apart -> wait_b low on the second until the first completes; both bytes land at consecutive addresses.
- Assert reset_b low during RD_WAIT -> all outputs return to reset values asynchronously; ptr=0.

Source files
------------

// File: rtl/ramdisk_io_ctrl.sv
// ramdisk_io_ctrl: IO-mapped RAM-disk engine streaming bytes to/from expansion SRAM via an auto-incrementing pointer.
// Shares the SRAM with CPU memory cycles, which always preempt an in-flight access.
module ramdisk_io_ctrl #(
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2,
  parameter int ADR_W     = 19
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             io_wr_stb,
  input  logic             io_rd_stb,
  input  logic [1:0]       io_reg,
  input  logic [7:0]       io_wdata,
  output logic [7:0]       io_rdata,
  output logic             wait_b,
  input  logic             cpu_req,
  output logic             sram_own,
  output logic [ADR_W-1:0] sram_adr,
  output logic [7:0]       sram_wdata,
  input  logic [7:0]       sram_rdata,
  output logic             sram_cs_b,
  output logic             sram_oe_b,
  output logic             sram_we_b
);
  typedef enum logic [2:0] {IDLE, ARB, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT, RD_SAMPLE} state_t;
  state_t r_state, w_next;
  logic [ADR_W-1:0] r_ptr;
  logic [7:0] r_rbuf, r_wbuf, r_hold_byte, r_rdata;
  logic r_rbuf_valid, r_wbuf_pend, r_pf_pend, r_hold_wr, r_hold_rd;
  logic [2:0] r_cnt;
  logic w_rd, w_adr_wr, w_adr_lo, w_data_wr, w_wr_acc, w_data_rd, w_rd_go;
  logic w_access, w_own, w_rd_st, w_wr_done, w_rd_done, w_busy;
  logic [23:0] w_p24, w_ld24;
  logic [7:0] w_rd_val;
  assign w_rd      = io_rd_stb & !io_wr_stb;
  assign w_adr_wr  = io_wr_stb & (io_reg != 2'd3);
  assign w_adr_lo  = io_wr_stb & (io_reg == 2'd0);
  assign w_data_wr = (io_wr_stb & (io_reg == 2'd3)) | r_hold_wr;
  assign w_wr_acc  = w_data_wr & !r_wbuf_pend;
  assign w_data_rd = (w_rd & (io_reg == 2'd3)) | r_hold_rd;
  assign w_rd_go   = w_data_rd & r_rbuf_valid;
  assign w_access  = (r_state != IDLE) && (r_state != ARB);
  assign w_own     = w_access & !cpu_req;
  assign w_rd_st   = (r_state == RD_SETUP) || (r_state == RD_WAIT) || (r_state == RD_SAMPLE);
  assign w_wr_done = (r_state == WR_HOLD) & !cpu_req;
  assign w_rd_done = (r_state == RD_SAMPLE) & !cpu_req;
  assign w_busy    = (r_state != IDLE) | r_wbuf_pend | r_pf_pend | r_hold_wr | r_hold_rd;
  assign w_p24     = 24'(r_ptr);
  assign w_ld24    = io_reg == 2'd0 ? {w_p24[23:8], io_wdata} :
                     io_reg == 2'd1 ? {w_p24[23:16], io_wdata, w_p24[7:0]} : {io_wdata, w_p24[15:0]};
  assign w_rd_val  = io_reg == 2'd0 ? w_p24[7:0] :
                     io_reg == 2'd1 ? w_p24[15:8] : {w_busy, r_rbuf_valid, w_p24[21:16]};
  // Strobes are gated by cpu_req combinationally so a memory cycle takes the SRAM in the same clock.
  assign sram_own   = w_own;
  assign sram_cs_b  = !w_own;
  assign sram_oe_b  = !(w_own & w_rd_st);
  assign sram_we_b  = !(w_own & (r_state == WR_PULSE));
  assign sram_adr   = r_ptr;
  assign sram_wdata = r_wbuf;
  assign io_rdata   = r_rdata;
  assign wait_b     = !(r_hold_wr | r_hold_rd);
  always_comb begin
    w_next = r_state;
    if (w_access && cpu_req) w_next = ARB;
    else
      case (r_state)
        IDLE:      w_next = (r_wbuf_pend | r_pf_pend) ? ARB : IDLE;
        ARB:       w_next = cpu_req ? ARB : r_wbuf_pend ? WR_SETUP : r_pf_pend ? RD_SETUP : IDLE;
        WR_SETUP:  w_next = WR_PULSE;
        WR_PULSE:  w_next = (r_cnt == 3'(WR_CYCLES - 1)) ? WR_HOLD : WR_PULSE;
        WR_HOLD:   w_next = IDLE;
        RD_SETUP:  w_next = (RD_CYCLES > 1) ? RD_WAIT : RD_SAMPLE;
        RD_WAIT:   w_next = (r_cnt == 3'(RD_CYCLES - 2)) ? RD_SAMPLE : RD_WAIT;
        RD_SAMPLE: w_next = IDLE;
        default:   w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_rbuf       <= '0;
      r_wbuf       <= '0;
      r_hold_byte  <= '0;
      r_rdata      <= '0;
      r_rbuf_valid <= 1'b0;
      r_wbuf_pend  <= 1'b0;
      r_pf_pend    <= 1'b0;
      r_hold_wr    <= 1'b0;
      r_hold_rd    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? 3'd0 : r_cnt + 3'd1;
      r_hold_wr <= w_data_wr & r_wbuf_pend;
      r_hold_rd <= w_data_rd & !r_rbuf_valid;
      if (io_wr_stb && io_reg == 2'd3) r_hold_byte <= io_wdata;
      if (w_wr_done) r_wbuf_pend <= 1'b0;
      if (w_wr_acc) begin
        r_wbuf      <= r_hold_wr ? r_hold_byte : io_wdata;
        r_wbuf_pend <= 1'b1;
      end
      if (w_rd && io_reg != 2'd3) r_rdata <= w_rd_val;
      if (w_rd_go) r_rdata <= r_rbuf;
      // A register write in the completion cycle wins: no increment, read data dropped.
      if (w_adr_wr) r_ptr <= ADR_W'(w_ld24);
      else if (w_wr_done | w_rd_go) r_ptr <= r_ptr + 1'b1;
      if (w_rd_done && !w_adr_wr) begin
        r_rbuf       <= sram_rdata;
        r_rbuf_valid <= 1'b1;
      end
      if (w_adr_lo | w_wr_done | w_rd_go) r_rbuf_valid <= 1'b0;
      if (w_rd_done) r_pf_pend <= 1'b0;
      if (w_adr_lo | w_wr_done | w_rd_go | (w_rd_done & w_adr_wr) | (w_data_rd & !r_rbuf_valid & !w_rd_done))
        r_pf_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ramdisk_io_ctrl.sv
// tb_ramdisk_io_ctrl: directed bench for ramdisk_io_ctrl with a behavioural SRAM.
module tb_ramdisk_io_ctrl;
  logic clk = 1'b0, reset_b = 1'b0, io_wr_stb = 1'b0, io_rd_stb = 1'b0, cpu_req = 1'b0;
  logic [1:0] io_reg = 2'd0;
  logic [7:0] io_wdata = 8'd0;
  logic [7:0] io_rdata, sram_wdata, sram_rdata;
  logic wait_b, sram_own, sram_cs_b, sram_oe_b, sram_we_b;
  logic [18:0] sram_adr;
  logic [7:0] mem [0:(1<<19)-1];
  logic [18:0] last_rd = '0;
  int we_cnt = 0;
  int vec = 0, errs = 0;

  ramdisk_io_ctrl dut (
    .clk(clk), .reset_b(reset_b), .io_wr_stb(io_wr_stb), .io_rd_stb(io_rd_stb),
    .io_reg(io_reg), .io_wdata(io_wdata), .io_rdata(io_rdata), .wait_b(wait_b),
    .cpu_req(cpu_req), .sram_own(sram_own), .sram_adr(sram_adr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_cs_b(sram_cs_b), .sram_oe_b(sram_oe_b), .sram_we_b(sram_we_b)
  );

  always #5 clk = ~clk;
  assign sram_rdata = mem[sram_adr];

  always @(posedge clk) begin
    if (sram_own && !sram_cs_b && !sram_we_b) begin
      mem[sram_adr] <= sram_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (sram_own && !sram_cs_b && !sram_oe_b) last_rd <= sram_adr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [7:0] d, output logic st);
    int n = 0;
    io_reg = r; io_wdata = d; io_wr_stb = 1'b1;
    @(negedge clk);
    io_wr_stb = 1'b0;
    while (!wait_b && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("wr_timeout", 32'(n), 0);
    st = (n > 0);
  endtask

  task automatic rd(input logic [1:0] r, output logic [7:0] d, output logic st);
    int n = 0;
    io_reg = r; io_rd_stb = 1'b1;
    @(negedge clk);
    io_rd_stb = 1'b0;
    while (!wait_b && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rd_timeout", 32'(n), 0);
    d = io_rdata;
    st = (n > 0);
  endtask

  task automatic setp(input logic [23:0] p);
    logic s;
    wr(2'd2, p[23:16], s);
    wr(2'd1, p[15:8], s);
    wr(2'd0, p[7:0], s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic s, s2, s3;
    int n, base;
    // reset state
    idle(2);
    chk("rst_wait_b", 32'(wait_b), 1);
    chk("rst_own", 32'(sram_own), 0);
    chk("rst_cs", 32'(sram_cs_b), 1);
    chk("rst_oe", 32'(sram_oe_b), 1);
    chk("rst_we", 32'(sram_we_b), 1);
    chk("rst_rdata", 32'(io_rdata), 0);
    reset_b = 1'b1;
    idle(2);
    rd(2'd2, d, s);
    chk("rst_status", 32'(d), 8'h00);
    // pointer load and prefetch
    setp(24'h053412);
    wr(2'd3, 8'h5A, s);
    idle(20);
    wr(2'd2, 8'h05, s);
    wr(2'd1, 8'h34, s);
    wr(2'd0, 8'h12, s);
    n = 0;
    while (!sram_own && n < 20) begin @(negedge clk); n++; end
    chk("pf_adr", 32'(sram_adr), 32'h53412);
    chk("pf_oe", 32'(sram_oe_b), 0);
    idle(10);
    rd(2'd2, d, s);
    chk("status_45", 32'(d), 8'h45);
    rd(2'd3, d, s);
    chk("data_5a", 32'(d), 8'h5A);
    rd(2'd0, d, s);
    chk("ptr_lo_13", 32'(d), 8'h13);
    idle(10);
    // write at top of address space, pointer wrap
    wr(2'd2, 8'hFF, s);
    wr(2'd1, 8'hFF, s);
    wr(2'd0, 8'hFF, s);
    base = we_cnt;
    wr(2'd3, 8'hA5, s);
    idle(20);
    chk("mem_7ffff", 32'(mem[19'h7FFFF]), 8'hA5);
    chk("we_cycles", 32'(we_cnt - base), 2);
    chk("wrap_pf_adr", 32'(last_rd), 0);
    rd(2'd0, d, s);
    chk("wrap_lo", 32'(d), 8'h00);
    rd(2'd2, d, s);
    chk("wrap_hi", 32'(d), 8'h40);
    // back-to-back reads
    setp(24'h000100);
    wr(2'd3, 8'h11, s);
    wr(2'd3, 8'h22, s);
    wr(2'd3, 8'h33, s);
    idle(30);
    wr(2'd0, 8'h00, s);
    idle(10);
    rd(2'd3, d, s);
    chk("rd1_data", 32'(d), 8'h11);
    rd(2'd3, d, s2);
    chk("rd2_data", 32'(d), 8'h22);
    rd(2'd3, d, s3);
    chk("rd3_data", 32'(d), 8'h33);
    chk("rd1_stall", 32'(s), 0);
    chk("rd2_stall", 32'(s2), 1);
    chk("rd3_stall", 32'(s3), 1);
    idle(10);
    rd(2'd0, d, s);
    chk("rd_ptr_lo", 32'(d), 8'h03);
    rd(2'd1, d, s);
    chk("rd_ptr_mid", 32'(d), 8'h01);
    // preemption during write pulse
    setp(24'h000200);
    idle(10);
    base = we_cnt;
    wr(2'd3, 8'h77, s);
    n = 0;
    while (sram_we_b && n < 20) begin @(negedge clk); n++; end
    chk("pulse_seen", 32'(sram_we_b), 0);
    cpu_req = 1'b1;
    #1;
    chk("pre_own", 32'(sram_own), 0);
    chk("pre_we", 32'(sram_we_b), 1);
    chk("pre_cs", 32'(sram_cs_b), 1);
    idle(4);
    chk("pre_hold_own", 32'(sram_own), 0);
    cpu_req = 1'b0;
    idle(20);
    chk("pre_mem", 32'(mem[19'h00200]), 8'h77);
    chk("pre_we_cycles", 32'(we_cnt - base), 2);
    rd(2'd0, d, s);
    chk("pre_ptr_lo", 32'(d), 8'h01);
    // two writes one clock apart
    setp(24'h000300);
    idle(10);
    wr(2'd3, 8'hB1, s);
    wr(2'd3, 8'hB2, s2);
    chk("w1_stall", 32'(s), 0);
    chk("w2_stall", 32'(s2), 1);
    idle(30);
    chk("w1_mem", 32'(mem[19'h00300]), 8'hB1);
    chk("w2_mem", 32'(mem[19'h00301]), 8'hB2);
    rd(2'd0, d, s);
    chk("w_ptr_lo", 32'(d), 8'h02);
    // async reset during read wait
    setp(24'h000400);
    n = 0;
    while (sram_oe_b && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("rdwait_oe", 32'(sram_oe_b), 0);
    reset_b = 1'b0;
    #1;
    chk("ar_own", 32'(sram_own), 0);
    chk("ar_cs", 32'(sram_cs_b), 1);
    chk("ar_oe", 32'(sram_oe_b), 1);
    chk("ar_we", 32'(sram_we_b), 1);
    chk("ar_wait_b", 32'(wait_b), 1);
    chk("ar_rdata", 32'(io_rdata), 0);
    @(negedge clk);
    reset_b = 1'b1;
    idle(2);
    rd(2'd1, d, s);
    chk("ar_ptr_mid", 32'(d), 8'h00);
    rd(2'd2, d, s);
    chk("ar_status", 32'(d), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
